// File: rtl/timer_pkg.sv
// Shared types and constants for the MM:SS countdown timer entry/load path.
package timer_pkg;

    localparam int unsigned BCD_W = 4;

    typedef logic [BCD_W-1:0] bcd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        LOAD  = 2'd2,
        ARMED = 2'd3
    } loader_state_t;

    localparam bcd_t BCD_MAX      = 4'd9;
    localparam bcd_t SEC_TENS_MAX = 4'd5;

endpackage

// File: rtl/bcd_shift_reg.sv
// MM:SS entry register: digits shift in from the right, with clear, first-digit load and seconds clamp.
module bcd_shift_reg
    import timer_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) (
    input  logic                      clock,
    input  logic                      clr,
    input  logic                      clear,
    input  logic                      load_first,
    input  logic                      shift_in,
    input  logic                      clamp,
    input  bcd_t                      din,
    output logic [DIGITS*BCD_W-1:0]   value
);

    localparam int unsigned REG_W = DIGITS * BCD_W;

    // Controls are mutually exclusive by construction in the loader FSM; order here is a safety net.
    always_ff @(posedge clock) begin
        if (clr || clear) begin
            value <= '0;
        end else if (load_first) begin
            value <= REG_W'(din);
        end else if (shift_in) begin
            value <= {value[REG_W-BCD_W-1:0], din};
        end else if (clamp) begin
            value[2*BCD_W-1:0] <= {SEC_TENS_MAX, BCD_MAX};
        end
    end

endmodule

// File: rtl/timer_entry_loader.sv
// Keypad-side writer for the MM:SS countdown chain: collects BCD digits and issues the load_n strobe.
// Optional build macro SEC_CLAMP_EN clamps seconds tens > 5 to 59 when a load starts.
module timer_entry_loader
    import timer_pkg::*;
#(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned LOAD_CYCLES = 1
) (
    input  logic       clock,
    input  logic       clr,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       start,
    input  logic       cancel,
    output logic       load_n,
    output bcd_t       min_tens,
    output bcd_t       min_ones,
    output bcd_t       sec_tens,
    output bcd_t       sec_ones,
    output logic [2:0] digit_count,
    output logic       ready
);

    localparam int unsigned REG_W = DIGITS * BCD_W;
    localparam int unsigned CNT_W = 3;

    loader_state_t    state, state_nx;
    logic [CNT_W-1:0] count_nx;
    logic [CNT_W-1:0] load_cnt, load_cnt_nx;
    logic             load_n_nx;
    logic             ready_nx;
    logic             enter_load;
    logic             sr_clear, sr_first, sr_shift, sr_clamp;
    logic             key_ok;
    logic             clamp_need;
    logic [REG_W-1:0] entry;

    assign key_ok = key_valid && (key_digit <= BCD_MAX);

`ifdef SEC_CLAMP_EN
    assign clamp_need = (entry[2*BCD_W-1:BCD_W] > SEC_TENS_MAX);
`else
    assign clamp_need = 1'b0;
`endif

    bcd_shift_reg #(.DIGITS(DIGITS)) u_entry (
        .clock      (clock),
        .clr        (clr),
        .clear      (sr_clear),
        .load_first (sr_first),
        .shift_in   (sr_shift),
        .clamp      (sr_clamp),
        .din        (key_digit),
        .value      (entry)
    );

    assign min_tens = entry[4*BCD_W-1 -: BCD_W];
    assign min_ones = entry[3*BCD_W-1 -: BCD_W];
    assign sec_tens = entry[2*BCD_W-1 -: BCD_W];
    assign sec_ones = entry[BCD_W-1   -: BCD_W];

    always_ff @(posedge clock) begin
        if (clr) begin
            state       <= IDLE;
            digit_count <= '0;
            load_cnt    <= '0;
            load_n      <= 1'b1;
            ready       <= 1'b1;
        end else begin
            state       <= state_nx;
            digit_count <= count_nx;
            load_cnt    <= load_cnt_nx;
            load_n      <= load_n_nx;
            ready       <= ready_nx;
        end
    end

    // Priority: cancel > start > key; load_n is low for exactly LOAD_CYCLES cycles per commit.
    always_comb begin
        state_nx    = state;
        count_nx    = digit_count;
        load_cnt_nx = load_cnt;
        load_n_nx   = 1'b1;
        enter_load  = 1'b0;
        sr_clear    = 1'b0;
        sr_first    = 1'b0;
        sr_shift    = 1'b0;
        sr_clamp    = 1'b0;

        if (cancel) begin
            state_nx    = IDLE;
            count_nx    = '0;
            load_cnt_nx = '0;
            sr_clear    = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (key_ok) begin
                        sr_first = 1'b1;
                        count_nx = CNT_W'(1);
                        state_nx = ENTRY;
                    end
                end
                ENTRY: begin
                    if (start) begin
                        if (entry != '0) begin
                            enter_load = 1'b1;
                        end else begin
                            sr_clear = 1'b1;
                            count_nx = '0;
                            state_nx = IDLE;
                        end
                    end else if (key_ok && (digit_count < CNT_W'(DIGITS))) begin
                        sr_shift = 1'b1;
                        count_nx = digit_count + CNT_W'(1);
                    end
                end
                LOAD: begin
                    if (load_cnt == CNT_W'(LOAD_CYCLES - 1)) begin
                        state_nx = ARMED;
                    end else begin
                        load_cnt_nx = load_cnt + CNT_W'(1);
                        load_n_nx   = 1'b0;
                    end
                end
                ARMED: begin
                    if (start) begin
                        enter_load = 1'b1;
                    end else if (key_ok) begin
                        sr_first = 1'b1;
                        count_nx = CNT_W'(1);
                        state_nx = ENTRY;
                    end
                end
                default: state_nx = IDLE;
            endcase

            if (enter_load) begin
                state_nx    = LOAD;
                load_cnt_nx = '0;
                load_n_nx   = 1'b0;
                sr_clamp    = clamp_need;
            end
        end

        ready_nx = (state_nx == IDLE) || (state_nx == ARMED);
    end

endmodule
